// File: rtl/multi_cycle_seq_pkg.sv
// Shared CPU definitions: multi-cycle sequencer state codes and helpers.
package multi_cycle_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } cpuState_e;

  // States whose exit back to IF completes an instruction.
  function automatic logic isRetireSrc(input logic [STATE_W-1:0] s);
    return (s == S_EX) || (s == S_MEM) || (s == S_WB);
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running completed-instruction counter; wraps silently, one-cycle update.
module retire_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/multi_cycle_seq.sv
// Multi-cycle CPU sequencer IF/ID/EX/MEM/WB; 3-5 cycles per instruction at zero wait.
// IF stalls on imem_ready, MEM stalls on dmem_ready; strobes drop as soon as rst_n falls.
module multi_cycle_seq
  import multi_cycle_seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_regwe,
  input  logic             dec_jump,
  input  logic             br_taken,
  output logic             imem_re,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             reg_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  logic [STATE_W-1:0] stateQ;
  logic [STATE_W-1:0] stateD;

  logic latLoad;
  logic latStore;
  logic latRegWe;
  logic latJump;
  logic storeEff;
  logic taken;

  logic imemReC;
  logic irWeC;
  logic pcWeC;
  logic pcSrcC;
  logic dmemReC;
  logic dmemWeC;
  logic regWeC;
  logic retireEn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= S_IF;
    end else begin
      stateQ <= stateD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latLoad  <= 1'b0;
      latStore <= 1'b0;
      latRegWe <= 1'b0;
      latJump  <= 1'b0;
    end else if (stateQ == S_ID) begin
      latLoad  <= dec_load;
      latStore <= dec_store;
      latRegWe <= dec_regwe;
      latJump  <= dec_jump;
    end
  end

  // A decode flagging both load and store is executed as a load.
  assign storeEff = latStore & ~latLoad;
  assign taken    = latJump | br_taken;

  always_comb begin
    stateD  = S_IF;
    imemReC = 1'b0;
    irWeC   = 1'b0;
    pcWeC   = 1'b0;
    pcSrcC  = 1'b0;
    dmemReC = 1'b0;
    dmemWeC = 1'b0;
    regWeC  = 1'b0;
    case (stateQ)
      S_IF: begin
        imemReC = 1'b1;
        if (imem_ready) begin
          irWeC  = 1'b1;
          pcWeC  = 1'b1;
          stateD = S_ID;
        end else begin
          stateD = S_IF;
        end
      end
      S_ID: begin
        stateD = S_EX;
      end
      S_EX: begin
        pcWeC  = taken;
        pcSrcC = taken;
        if (latLoad || latStore) begin
          stateD = S_MEM;
        end else if (latRegWe) begin
          stateD = S_WB;
        end else begin
          stateD = S_IF;
        end
      end
      S_MEM: begin
        dmemReC = latLoad;
        dmemWeC = storeEff;
        if (!dmem_ready) begin
          stateD = S_MEM;
        end else if (latLoad) begin
          stateD = S_WB;
        end else begin
          stateD = S_IF;
        end
      end
      S_WB: begin
        regWeC = 1'b1;
        stateD = S_IF;
      end
      default: begin
        stateD = S_IF;
      end
    endcase
  end

  // Gating by rst_n keeps every strobe low for the whole reset window.
  assign imem_re = imemReC & rst_n;
  assign ir_we   = irWeC & rst_n;
  assign pc_we   = pcWeC & rst_n;
  assign pc_src  = pcSrcC & rst_n;
  assign dmem_re = dmemReC & rst_n;
  assign dmem_we = dmemWeC & rst_n;
  assign reg_we  = regWeC & rst_n;
  assign state   = stateQ;

  assign retireEn = isRetireSrc(stateQ) && (stateD == S_IF);

  retire_counter #(
    .W(CNT_W)
  ) uRetire (
    .enable(retireEn),
    .clk   (clk),
    .rst_n (rst_n),
    .count (retired)
  );

endmodule

// File: doc/multi_cycle_seq.md
MULTI_CYCLE_SEQ -- requirements
Module: multi_cycle_seq

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of the retired-instruction counter.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: imem_ready  input  1  instruction memory read data valid this cycle.
REQ-005 SHALL have port: dmem_ready  input  1  data memory access complete this cycle.
REQ-006 SHALL have port: dec_load  input  1  ControlUnit sLoad (lw/lb).
REQ-007 SHALL have port: dec_store  input  1  ControlUnit dMemWe (sw/sb).
REQ-008 SHALL have port: dec_regwe  input  1  ControlUnit regWe (incl. link writes of bal/bltzal/bgezal/jal).
REQ-009 SHALL have port: dec_jump  input  1  j/jal/jr decoded.
REQ-010 SHALL have port: br_taken  input  1  branch unit condition true (valid in EX only).
REQ-011 SHALL have port: imem_re  output  1  instruction fetch request.
REQ-012 SHALL have port: ir_we  output  1  instruction register load strobe.
REQ-013 SHALL have port: pc_we  output  1  PC write strobe.
REQ-014 SHALL have port: pc_src  output  1  0 = PC+4, 1 = branch/jump target.
REQ-015 SHALL have port: dmem_re  output  1  data read request.
REQ-016 SHALL have port: dmem_we  output  1  data write request.
REQ-017 SHALL have port: reg_we  output  1  register file write strobe.
REQ-018 SHALL have port: state  output  3  current FSM state code.
REQ-019 SHALL have port: retired  output  CNT_W  instructions completed since reset.

Function
REQ-020 FSM states SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 SHALL transition to IF on the next edge with all strobes low.
REQ-021 IF: imem_re=1; stay until imem_ready=1; in that cycle ir_we=1, pc_we=1, pc_src=0; next state ID.
REQ-022 ID: one cycle; dec_load, dec_store, dec_regwe, dec_jump SHALL be latched at the end of ID; later states use only latched copies.
REQ-023 Latched load and store both 1 SHALL be treated as load only (store suppressed).
REQ-024 EX: one cycle; pc_we=1, pc_src=1 iff latched jump OR br_taken; br_taken ignored outside EX.
REQ-025 EX next state: MEM if load or store; else WB if regwe; else IF.
REQ-026 MEM: dmem_re=1 (load) or dmem_we=1 (store), held constant until dmem_ready=1; on ready: load -> WB, store -> IF.
REQ-027 WB: reg_we=1 for exactly one cycle; next state IF.
REQ-028 retired SHALL increment by 1 on every transition into IF from EX, MEM or WB; wraps modulo 2^CNT_W without flag.
REQ-029 All strobes (imem_re, ir_we, pc_we, dmem_re, dmem_we, reg_we) SHALL be decoded from state (and ready inputs where stated) only; never more than one of dmem_re/dmem_we high.
REQ-030 Zero-wait latency (ready tied 1): R-type/ALU-imm 4 cycles, load 5, store 4, branch/j 3, jal/bal 4.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IF, retired=0, latched decode=0, and all strobes low except imem_re, which asserts on the first cycle after rst_n releases.
REQ-032 Reset asserted mid-MEM SHALL drop dmem_we/dmem_re immediately, without waiting for dmem_ready.

Structure
REQ-033 State codes (IF..WB) and their 3-bit width SHALL be defined in the shared CPU package used by ControlUnit.
REQ-034 The retired counter SHALL be a sub-module named retire_counter (enable, clk, rst_n, count).

Verification
REQ-035 Ready tied 1, addu (regwe=1): state sequence 0,1,2,4,0; reg_we high only in cycle 4; retired 0->1.
REQ-036 lw with dmem_ready low for 3 MEM cycles: dmem_re high 4 cycles, then WB, total 8 cycles, retired +1.
REQ-037 beq with br_taken=1 in EX: pc_we with pc_src=1 in cycle 3, next IF, no reg_we; with br_taken=0: no pc_we in EX.
REQ-038 dec_load=dec_store=1: dmem_re only, dmem_we never asserted, WB reached.
REQ-039 rst_n pulsed low during MEM of sw: dmem_we falls within same cycle, state=0, retired=0.
REQ-040 retired preset near wrap (CNT_W=4, 15 instructions then 1 more): count 15 -> 0.
